// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// default latencies and small op-classification helpers.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_arith(input logic [2:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational multiply/divide datapath working on the latched operands.
// wr_en drops on divide by zero so HI/LO keep their previous contents.
module mdu_core
  import mdu_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] next_hi,
  output logic [31:0] next_lo,
  output logic        wr_en
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_b;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    next_hi    = 32'd0;
    next_lo    = 32'd0;
    wr_en      = 1'b0;
    signed_div = (op == OP_DIV);
    neg_a      = signed_div & a[31];
    neg_b      = signed_div & b[31];
    mag_a      = neg_a ? (32'd0 - a) : a;
    mag_b      = neg_b ? (32'd0 - b) : b;
    div_b      = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quo_u      = mag_a / div_b;
    rem_u      = mag_a % div_b;

    case (op_e'(op))
      OP_MULT: begin
        {next_hi, next_lo} = prod_s;
        wr_en              = 1'b1;
      end
      OP_MULTU: begin
        {next_hi, next_lo} = prod_u;
        wr_en              = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        next_lo = (neg_a ^ neg_b) ? (32'd0 - quo_u) : quo_u;
        next_hi = neg_a ? (32'd0 - rem_u) : rem_u;
        wr_en   = (b != 32'd0);
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer beside the E-stage ALU: latches operands,
// counts out the fixed latency, commits HI/LO and raises the D-stage stall.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        load;
  logic [31:0] core_hi, core_lo;
  logic        core_wr;

  mdu_core u_core (
    .a       (a_q),
    .b       (b_q),
    .op      (op_q),
    .next_hi (core_hi),
    .next_lo (core_lo),
    .wr_en   (core_wr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_arith(op)) begin
            load    = 1'b1;
            cnt_d   = is_div(op) ? DIV_CNT : MUL_CNT;
            state_d = S_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_RUN: begin
        // Commands arriving here are dropped; the pipeline stall prevents them.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (core_wr) begin
            hi_d = core_hi;
            lo_d = core_lo;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (load) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == S_RUN);
  assign stall = req_md & (busy | (start & is_arith(op)));

endmodule
